load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Sits between the execute stage and the word-addressed data memory (1024 x 32, sync write, comb read).
//   Converts RV32I loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW) into word accesses.
//   Sub-word stores become read-modify-write sequences. Misaligned and out-of-range accesses are faulted.
//   Results return to writeback over a valid/ready response channel.
// PARAMETERS
//   MEM_WORDS  1024  data memory depth in words; legal byte addresses are 0 .. 4*MEM_WORDS-1
// PORTS
//   clk           in   1   clock
//   rst           in   1   synchronous reset, active-high
//   req_valid     in   1   execute presents an access
//   req_ready     out  1   LSU accepts the access this cycle
//   req_we        in   1   1=store, 0=load
//   req_funct3    in   3   RV32I width/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr      in   32  byte address
//   req_wdata     in   32  store data (LSBs used for B/H)
//   rsp_valid     out  1   response pending
//   rsp_ready     in   1   writeback consumes the response
//   rsp_rdata     out  32  extended load data; 0 for stores and faults
//   rsp_misalign  out  1   H access with addr[0]!=0, or W access with addr[1:0]!=0
//   rsp_oor       out  1   addr >= 4*MEM_WORDS
//   mem_we        out  1   to data memory WE
//   mem_addr      out  32  to data memory A; always word aligned ({addr[31:2],2'b00})
//   mem_wdata     out  32  to data memory WD
//   mem_rdata     in   32  from data memory RD (combinational)
// BEHAVIOUR
//   Reset: state=IDLE; rsp_valid=0, rsp_rdata=0, rsp_misalign=0, rsp_oor=0.
//     While rst=1: req_ready=0 and mem_we=0. Reset mid-RMW abandons the write; no mem_we is issued.
//   FSM states: IDLE, RMW, RESP.
//     req_ready=1 only in IDLE. Handshake is req_valid&req_ready.
//   IDLE, accept:
//     - Fault (misalign or oor; both flags may set) -> no mem_we -> RESP.
//     - Load -> mem_addr=aligned addr this cycle.
//       Extract lane by addr[1:0] (H uses addr[1]); sign-/zero-extend per funct3; register into rsp_rdata.
//       -> RESP. Latency: rsp_valid in cycle N+1.
//     - SW -> mem_we=1 with mem_wdata=req_wdata in cycle N -> RESP (rsp_valid N+1).
//     - SB/SH -> latch addr/wdata/funct3 -> RMW.
//   RMW (cycle N+1):
//     - Drive latched aligned addr. Merge byte/half into mem_rdata at the latched lane; other bytes unchanged.
//     - mem_we=1 -> RESP (rsp_valid N+2).
//   RESP: rsp_* held stable until rsp_ready=1 -> IDLE.
//     rsp_ready=0 stalls indefinitely; req_ready stays 0.
//   mem_we=0 in every cycle not listed above. mem_addr/mem_wdata are don't-care when idle but must not be X.
//   Illegal funct3 (011, 110, 111): treated as misaligned fault (rsp_misalign=1).
//   Accesses are strictly in order; at most one outstanding.
// STRUCTURE
//   Shared package lsu_pkg:
//     - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
//     - state encoding (IDLE/RMW/RESP)
//   One combinational sub-module lsu_align:
//     - load lane extract and sign/zero extend
//     - store lane merge
//     - misalign detection
// TESTING
//   1. SW 0xDEADBEEF @0x10, then LW @0x10 -> mem_we pulse at accept cycle; load rsp_rdata=0xDEADBEEF at N+1.
//   2. SB 0xAA @0x11 over word 0x11223344 -> mem_we at N+1 only, mem_wdata=0x1122AA44; rsp_valid N+2.
//      Then LB @0x11 -> 0xFFFFFFAA; LBU @0x11 -> 0x000000AA.
//   3. SH 0x8001 @0x22 over 0 -> word 0x80010000.
//      Then LH @0x22 -> 0xFFFF8001; LHU -> 0x00008001.
//   4. LW @0x6, SH @0x3, LW @0x1000 (MEM_WORDS=1024):
//      -> misalign=1 / misalign=1 / oor=1; no mem_we; rdata=0.
//   5. Hold rsp_ready=0 for 5 cycles -> rsp stable, req_ready=0.
//      Then rsp_ready=1 -> IDLE next cycle, new request accepted.
//   6. Assert rst in RMW cycle of SB -> no mem_we; memory word unchanged; outputs at reset values next cycle.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes and FSM encoding.
package lsu_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RMW  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;
endpackage

// File: rtl/lsu_if.sv
// Execute-side request channel and writeback-side response channel of the LSU.
interface lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic        rsp_oor;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misalign, rsp_oor
    );
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_misalign, rsp_oor
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane logic: load extract/extend, sub-word store merge, alignment check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  lane,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data,
    output logic        misalign
);
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] mask;
    logic [31:0] data_rep;

    always_comb begin
        shifted = word >> {lane, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = lane[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_B:    load_data = {{24{byte_v[7]}}, byte_v};
            F3_BU:   load_data = {24'h0, byte_v};
            F3_H:    load_data = {{16{half_v[15]}}, half_v};
            F3_HU:   load_data = {16'h0, half_v};
            default: load_data = word;
        endcase

        // funct3[1:0] carries the access width for both signed and unsigned codes
        case (funct3[1:0])
            2'b00: begin
                mask     = 32'h0000_00FF << {lane, 3'b000};
                data_rep = {4{wdata[7:0]}};
            end
            2'b01: begin
                mask     = lane[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
                data_rep = {2{wdata[15:0]}};
            end
            default: begin
                mask     = 32'hFFFF_FFFF;
                data_rep = wdata;
            end
        endcase
        merge_data = (word & ~mask) | (data_rep & mask);

        case (funct3)
            F3_B, F3_BU: misalign = 1'b0;
            F3_H, F3_HU: misalign = lane[0];
            F3_W:        misalign = |lane;
            default:     misalign = 1'b1;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit in front of a word-addressed memory; sub-word stores use read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    lsu_if.slave        bus,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);
    localparam logic [31:0] ADDR_LIM = 32'(4 * MEM_WORDS);

    lsu_state_t  state, next;
    logic [31:0] lat_addr, lat_wdata;
    logic [2:0]  lat_f3;
    logic [31:0] sel_addr, sel_wdata;
    logic [2:0]  sel_f3;
    logic [31:0] load_data, merge_data;
    logic        misalign, oor, fault, accept;

    // The RMW cycle replays the latched request through the same lane logic
    assign sel_addr  = (state == ST_RMW) ? lat_addr  : bus.req_addr;
    assign sel_wdata = (state == ST_RMW) ? lat_wdata : bus.req_wdata;
    assign sel_f3    = (state == ST_RMW) ? lat_f3    : bus.req_funct3;

    lsu_align u_align (
        .funct3     (sel_f3),
        .lane       (sel_addr[1:0]),
        .word       (mem_rdata),
        .wdata      (sel_wdata),
        .load_data  (load_data),
        .merge_data (merge_data),
        .misalign   (misalign)
    );

    assign oor           = bus.req_addr >= ADDR_LIM;
    assign fault         = misalign | oor;
    assign bus.req_ready = (state == ST_IDLE) && !rst;
    assign accept        = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid = (state == ST_RESP);
    assign mem_addr      = {sel_addr[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next;
    end

    always_comb begin
        next      = state;
        mem_we    = 1'b0;
        mem_wdata = sel_wdata;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (fault || !bus.req_we) begin
                        next = ST_RESP;
                    end else if (bus.req_funct3 == F3_W) begin
                        mem_we = 1'b1;
                        next   = ST_RESP;
                    end else begin
                        next = ST_RMW;
                    end
                end
            end
            ST_RMW: begin
                mem_we    = 1'b1;
                mem_wdata = merge_data;
                next      = ST_RESP;
            end
            ST_RESP: if (bus.rsp_ready) next = ST_IDLE;
            default: next = ST_IDLE;
        endcase
        if (rst) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr         <= '0;
            lat_wdata        <= '0;
            lat_f3           <= '0;
            bus.rsp_rdata    <= '0;
            bus.rsp_misalign <= 1'b0;
            bus.rsp_oor      <= 1'b0;
        end else if (accept) begin
            lat_addr         <= bus.req_addr;
            lat_wdata        <= bus.req_wdata;
            lat_f3           <= bus.req_funct3;
            bus.rsp_misalign <= misalign;
            bus.rsp_oor      <= oor;
            bus.rsp_rdata    <= (!fault && !bus.req_we) ? load_data : 32'h0;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: byte-array reference model, directed cases plus randomized accesses.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [31:0] mem [1024] = '{default: 32'h0};
    logic [7:0]  ref_bytes [4096];
    int          tests = 0;
    int          failed = 0;

    lsu_if bus ();

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int b;
        b = int'({a[11:2], 2'b00});
        return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
    endfunction

    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic logic ref_mis(input logic [2:0] f3, input logic [31:0] a);
        if (f3 == 3'b011 || f3 >= 3'b110) return 1'b1;
        return (a % ref_size(f3)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        int unsigned v = 0;
        int n = ref_size(f3);
        for (int i = 0; i < n; i++) v += int'(ref_bytes[int'(a) + i]) << (8 * i);
        if (f3 == 3'b000 && v >= 128)   v = v - 256;
        if (f3 == 3'b001 && v >= 32768) v = v - 65536;
        return 32'(v);
    endfunction

    // One complete transaction; stall = cycles rsp_ready is held low in RESP.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int stall);
        logic mis, oor, flt, rmw;
        logic [31:0] exp_rd, exp_word;
        mis = ref_mis(f3, a);
        oor = a >= 32'd4096;
        flt = mis || oor;
        rmw = we && !flt && f3 != 3'b010;
        exp_rd = (!we && !flt) ? ref_load(f3, a) : 32'h0;
        if (we && !flt)
            for (int i = 0; i < ref_size(f3); i++) ref_bytes[int'(a) + i] = wd[8*i +: 8];
        exp_word = ref_word(a);

        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        #1;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        chk("mem_addr_accept", mem_addr, {a[31:2], 2'b00});
        chk("mem_we_accept", 32'(mem_we), 32'(we && !flt && f3 == 3'b010));
        if (we && !flt && f3 == 3'b010) chk("mem_wdata_sw", mem_wdata, wd);
        @(negedge clk);
        bus.req_valid = 1'b0;
        if (rmw) begin
            chk("rmw_mem_we", 32'(mem_we), 32'd1);
            chk("rmw_mem_wdata", mem_wdata, exp_word);
            chk("rmw_mem_addr", mem_addr, {a[31:2], 2'b00});
            chk("rmw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
        end
        for (int s = 0; s <= stall; s++) begin
            chk("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("rsp_rdata", bus.rsp_rdata, exp_rd);
            chk("rsp_misalign", 32'(bus.rsp_misalign), 32'(mis));
            chk("rsp_oor", 32'(bus.rsp_oor), 32'(oor));
            chk("resp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("resp_mem_we", 32'(mem_we), 32'd0);
            if (s < stall) @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        chk("back_idle_valid", 32'(bus.rsp_valid), 32'd0);
        chk("back_idle_ready", 32'(bus.req_ready), 32'd1);
        if (!oor) chk("mem_word", mem[a[11:2]], exp_word);
    endtask

    initial begin
        logic [2:0] f3;
        logic [31:0] a;
        logic we;
        int r;
        for (int i = 0; i < 4096; i++) ref_bytes[i] = 8'h0;
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0; bus.rsp_ready = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b0;
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_flags", {30'h0, bus.rsp_misalign, bus.rsp_oor}, 32'h0);

        access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
        access(1'b0, 3'b010, 32'h10, 32'h0, 0);
        access(1'b1, 3'b010, 32'h10, 32'h11223344, 0);
        access(1'b1, 3'b000, 32'h11, 32'h000000AA, 0);
        chk("sb_word", mem[4], 32'h1122AA44);
        access(1'b0, 3'b000, 32'h11, 32'h0, 0);
        access(1'b0, 3'b100, 32'h11, 32'h0, 0);
        access(1'b1, 3'b001, 32'h22, 32'h00008001, 0);
        chk("sh_word", mem[8], 32'h80010000);
        access(1'b0, 3'b001, 32'h22, 32'h0, 0);
        access(1'b0, 3'b101, 32'h22, 32'h0, 0);
        access(1'b0, 3'b010, 32'h6, 32'h0, 0);
        access(1'b1, 3'b001, 32'h3, 32'h1234, 0);
        access(1'b0, 3'b010, 32'h1000, 32'h0, 0);
        access(1'b0, 3'b011, 32'h8, 32'h0, 0);
        access(1'b1, 3'b010, 32'hFFC, 32'hCAFEF00D, 0);
        access(1'b0, 3'b010, 32'hFFC, 32'h0, 5);

        // reset during the RMW cycle must drop the pending write
        @(negedge clk);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'b000;
        bus.req_addr = 32'h10; bus.req_wdata = 32'h55;
        @(negedge clk);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_rmw_mem_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        chk("rst_rmw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rmw_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rmw_req_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rmw_word", mem[4], ref_word(32'h10));
        chk("rst_rmw_idle", 32'(bus.req_ready), 32'd1);

        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            r  = int'($urandom_range(0, 9));
            if (we) f3 = (r == 9) ? 3'b111 : 3'($urandom_range(0, 2));
            else    f3 = 3'($urandom_range(0, 7));
            if (r == 0) a = 32'h1000 + $urandom_range(0, 32'h3FFF);
            else        a = $urandom_range(0, 63);
            access(we, f3, a, $urandom, int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
